// File: rtl/exe_stage_if.sv
// rtl/exe_stage_if.sv - ID/EXE to EXE/MEM bus bundle for the execute stage
//
// Purpose: groups the ID/EXE operand/control inputs, the EXE/MEM registered
// outputs, the zero flag and the stall request of exe_stage into one bundle.
//
// Signals:
//   exe_a, exe_b, exe_imm  32  operands and immediate from ID/EXE
//   exe_rn                  5  destination register number
//   exe_aluc                3  operation select
//   exe_wreg, exe_m2reg, exe_wmem, exe_aluimm, exe_shift, exe_wz  control bits
//   exe_stall               1  hold request to IF/ID and ID/EXE
//   mem_alu, mem_b         32  registered result and store data
//   mem_rn                  5  registered destination register
//   mem_wreg, mem_m2reg, mem_wmem  registered control bits
//   z                       1  zero-flag register
//
// Modports: slave is the execute stage, master is the upstream/downstream side.
interface exe_stage_if;
  logic [31:0] exe_a;
  logic [31:0] exe_b;
  logic [31:0] exe_imm;
  logic [4:0]  exe_rn;
  logic [2:0]  exe_aluc;
  logic        exe_wreg;
  logic        exe_m2reg;
  logic        exe_wmem;
  logic        exe_aluimm;
  logic        exe_shift;
  logic        exe_wz;
  logic        exe_stall;
  logic [31:0] mem_alu;
  logic [31:0] mem_b;
  logic [4:0]  mem_rn;
  logic        mem_wreg;
  logic        mem_m2reg;
  logic        mem_wmem;
  logic        z;

  modport slave (
    input  exe_a, exe_b, exe_imm, exe_rn, exe_aluc,
    input  exe_wreg, exe_m2reg, exe_wmem, exe_aluimm, exe_shift, exe_wz,
    output exe_stall,
    output mem_alu, mem_b, mem_rn, mem_wreg, mem_m2reg, mem_wmem, z
  );

  modport master (
    output exe_a, exe_b, exe_imm, exe_rn, exe_aluc,
    output exe_wreg, exe_m2reg, exe_wmem, exe_aluimm, exe_shift, exe_wz,
    input  exe_stall,
    input  mem_alu, mem_b, mem_rn, mem_wreg, mem_m2reg, mem_wmem, z
  );
endinterface

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - pipeline execute stage with ALU, shifter and iterative multiply
//
// Purpose: single-cycle ALU/shift operations, a 32-cycle radix-2 shift-add
// multiply and the zero flag. Results are registered, so this block is also
// the EXE/MEM pipeline register. A multiply raises exe_stall to freeze the
// upstream pipeline until the product is ready.
//
// Ports:
//   clk   in  1  pipeline clock, rising edge
//   clrn  in  1  asynchronous active-low reset
//   bus   slave modport of exe_stage_if (ID/EXE inputs, EXE/MEM outputs,
//         zero flag, stall request)
module exe_stage (
  input  logic        clk,
  input  logic        clrn,
  exe_stage_if.slave  bus
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SRA = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        stall_c;

  logic [4:0]  count;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] prod;
  logic [31:0] prod_step;
  logic [4:0]  rn_l;
  logic        wz_l;
  logic        m2reg_l;

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_res;
  logic        start;
  logic        last;

  logic [31:0] mem_alu_r;
  logic [31:0] mem_b_r;
  logic [4:0]  mem_rn_r;
  logic        mem_wreg_r;
  logic        mem_m2reg_r;
  logic        mem_wmem_r;
  logic        z_r;

  // Operand selection: shift amount comes from the sa field of the immediate.
  assign op_a = bus.exe_shift  ? {27'b0, bus.exe_imm[10:6]} : bus.exe_a;
  assign op_b = bus.exe_aluimm ? bus.exe_imm : bus.exe_b;

  // A bubble (wreg=0) carrying a stale MUL opcode must not start a multiply.
  assign start = (state == IDLE) && (bus.exe_aluc == ALU_MUL) && bus.exe_wreg;
  assign last  = (state == MUL) && (count == 5'd31);

  always_comb begin
    alu_res = 32'd0;
    case (bus.exe_aluc)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_SLL: alu_res = op_b << op_a[4:0];
      ALU_SRL: alu_res = op_b >> op_a[4:0];
      ALU_SRA: alu_res = $unsigned($signed(op_b) >>> op_a[4:0]);
      // MUL goes through the iterative datapath; the single-cycle path
      // only sees it as a bubble, whose result is never consumed.
      ALU_MUL: alu_res = 32'd0;
      default: alu_res = 32'd0;
    endcase
  end

  // One shift-add iteration: multiplier bit 0 selects the shifted multiplicand.
  assign prod_step = prod + (mplier[0] ? mcand : 32'd0);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = MUL;
          stall_c   = 1'b1;
        end
      end
      MUL: begin
        if (count == 5'd31) begin
          state_nxt = IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stall is masked by reset so upstream is released as soon as clrn drops.
  assign bus.exe_stall = stall_c & clrn;

  // Multiply datapath: operand latches, partial product and iteration count.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      count   <= 5'd0;
      mcand   <= 32'd0;
      mplier  <= 32'd0;
      prod    <= 32'd0;
      rn_l    <= 5'd0;
      wz_l    <= 1'b0;
      m2reg_l <= 1'b0;
    end else if (start) begin
      count   <= 5'd0;
      mcand   <= op_a;
      mplier  <= op_b;
      prod    <= 32'd0;
      rn_l    <= bus.exe_rn;
      wz_l    <= bus.exe_wz;
      m2reg_l <= bus.exe_m2reg;
    end else if (state == MUL) begin
      count  <= count + 5'd1;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      prod   <= prod_step;
    end
  end

  // EXE/MEM pipeline register and zero flag.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mem_alu_r   <= 32'd0;
      mem_b_r     <= 32'd0;
      mem_rn_r    <= 5'd0;
      mem_wreg_r  <= 1'b0;
      mem_m2reg_r <= 1'b0;
      mem_wmem_r  <= 1'b0;
      z_r         <= 1'b0;
    end else if (last) begin
      mem_alu_r   <= prod_step;
      mem_rn_r    <= rn_l;
      mem_wreg_r  <= 1'b1;
      mem_m2reg_r <= m2reg_l;
      mem_wmem_r  <= 1'b0;
      if (wz_l) begin
        z_r <= (prod_step == 32'd0);
      end
    end else if (start || (state == MUL)) begin
      // Bubble while the multiply is in flight.
      mem_wreg_r  <= 1'b0;
      mem_m2reg_r <= 1'b0;
      mem_wmem_r  <= 1'b0;
    end else begin
      mem_alu_r   <= alu_res;
      mem_b_r     <= bus.exe_b;
      mem_rn_r    <= bus.exe_rn;
      mem_wreg_r  <= bus.exe_wreg;
      mem_m2reg_r <= bus.exe_m2reg;
      mem_wmem_r  <= bus.exe_wmem;
      if (bus.exe_wz) begin
        z_r <= (alu_res == 32'd0);
      end
    end
  end

  assign bus.mem_alu   = mem_alu_r;
  assign bus.mem_b     = mem_b_r;
  assign bus.mem_rn    = mem_rn_r;
  assign bus.mem_wreg  = mem_wreg_r;
  assign bus.mem_m2reg = mem_m2reg_r;
  assign bus.mem_wmem  = mem_wmem_r;
  assign bus.z         = z_r;

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - self-checking bench for exe_stage against an instruction-level model
module tb_exe_stage;

  logic clk;
  logic clrn;
  int   checks;
  int   errors;
  logic exp_z;

  exe_stage_if bus ();

  exe_stage dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", tag, got, exp);
    end
  endtask

  // Reference result of one instruction, written directly from the opcode table.
  function automatic logic [31:0] ref_result(input logic [2:0] aluc,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] ext;
    int          sh;
    sh  = int'(a[4:0]);
    ext = {{32{b[31]}}, b};
    case (aluc)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return b << sh;
      3'd5:    return b >> sh;
      3'd6:    begin ext = ext >> sh; return ext[31:0]; end
      default: return a * b;
    endcase
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic [4:0] rn, input logic [2:0] aluc,
                       input logic wreg, input logic m2reg, input logic wmem,
                       input logic aluimm, input logic shift, input logic wz);
    bus.exe_a      = a;
    bus.exe_b      = b;
    bus.exe_imm    = imm;
    bus.exe_rn     = rn;
    bus.exe_aluc   = aluc;
    bus.exe_wreg   = wreg;
    bus.exe_m2reg  = m2reg;
    bus.exe_wmem   = wmem;
    bus.exe_aluimm = aluimm;
    bus.exe_shift  = shift;
    bus.exe_wz     = wz;
  endtask

  // Called with clk low; returns with clk low after the instruction completes.
  task automatic run_instr(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                           input logic [4:0] rn, input logic [2:0] aluc,
                           input logic wreg, input logic m2reg, input logic wmem,
                           input logic aluimm, input logic shift, input logic wz);
    logic [31:0] oa, ob, res;
    drive(a, b, imm, rn, aluc, wreg, m2reg, wmem, aluimm, shift, wz);
    oa  = shift ? {27'b0, imm[10:6]} : a;
    ob  = aluimm ? imm : b;
    res = ref_result(aluc, oa, ob);
    if (aluc == 3'd7 && wreg) begin
      for (int i = 0; i < 32; i++) begin
        #1 check("mul_stall_hi", bus.exe_stall, 1'b1);
        @(posedge clk);
        #1;
        check("mul_bubble_wreg", bus.mem_wreg, 1'b0);
        check("mul_bubble_wmem", bus.mem_wmem, 1'b0);
        @(negedge clk);
      end
      #1 check("mul_stall_lo", bus.exe_stall, 1'b0);
      @(posedge clk);
      #1;
      if (wz) exp_z = (res == 32'd0);
      check("mul_alu", bus.mem_alu, res);
      check("mul_rn", bus.mem_rn, rn);
      check("mul_wreg", bus.mem_wreg, 1'b1);
      check("mul_wmem", bus.mem_wmem, 1'b0);
      check("mul_m2reg", bus.mem_m2reg, m2reg);
      check("mul_z", bus.z, exp_z);
      @(negedge clk);
    end else begin
      #1 check("op_stall", bus.exe_stall, 1'b0);
      @(posedge clk);
      #1;
      if (wz) exp_z = (res == 32'd0);
      if (aluc != 3'd7) check("op_alu", bus.mem_alu, res);
      check("op_b", bus.mem_b, b);
      check("op_rn", bus.mem_rn, rn);
      check("op_wreg", bus.mem_wreg, wreg);
      check("op_m2reg", bus.mem_m2reg, m2reg);
      check("op_wmem", bus.mem_wmem, wmem);
      check("op_z", bus.z, exp_z);
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_alu"}, bus.mem_alu, 32'd0);
    check({tag, "_b"}, bus.mem_b, 32'd0);
    check({tag, "_rn"}, bus.mem_rn, 5'd0);
    check({tag, "_wreg"}, bus.mem_wreg, 1'b0);
    check({tag, "_m2reg"}, bus.mem_m2reg, 1'b0);
    check({tag, "_wmem"}, bus.mem_wmem, 1'b0);
    check({tag, "_z"}, bus.z, 1'b0);
    check({tag, "_stall"}, bus.exe_stall, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_z  = 1'b0;
    clrn   = 1'b0;
    // A live MUL on the inputs during reset must not raise the stall.
    drive(32'd7, 32'd3, 32'd0, 5'd1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #1 check_reset_outputs("rst");
    drive(32'd0, 32'd0, 32'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    clrn = 1'b1;

    // Directed cases.
    run_instr(32'd5, 32'hFFFFFFFB, 32'd0, 5'd3, 3'd0, 1, 0, 0, 0, 0, 1);
    run_instr(32'h80000000, 32'd1, 32'd0, 5'd4, 3'd1, 1, 0, 0, 0, 0, 1);
    run_instr(32'd0, 32'h80000000, 32'h00000100, 5'd5, 3'd6, 1, 0, 0, 0, 1, 0);
    run_instr(32'h100, 32'hDEADBEEF, 32'd8, 5'd0, 3'd0, 0, 0, 1, 1, 0, 0);
    run_instr(32'd7, 32'hFFFFFFFD, 32'd0, 5'd9, 3'd7, 1, 0, 0, 0, 0, 1);
    run_instr(32'd10, 32'd20, 32'd0, 5'd6, 3'd0, 1, 0, 0, 0, 0, 1);
    // Stale MUL opcode in a bubble: no stall, no write.
    run_instr(32'd3, 32'd4, 32'd0, 5'd7, 3'd7, 0, 0, 0, 0, 0, 0);
    run_instr(32'd0, 32'd0, 32'd0, 5'd8, 3'd7, 1, 1, 0, 0, 0, 1);

    // Reset in the middle of a multiply.
    drive(32'd123, 32'd456, 32'd0, 5'd11, 3'd7, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 11; i++) @(negedge clk);
    clrn = 1'b0;
    #1 check_reset_outputs("midmul_rst");
    exp_z = 1'b0;
    drive(32'd1, 32'd2, 32'd0, 5'd12, 3'd0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    clrn = 1'b1;
    run_instr(32'd1, 32'd2, 32'd0, 5'd12, 3'd0, 1, 0, 0, 0, 0, 0);
    run_instr(32'd9, 32'd9, 32'd0, 5'd13, 3'd2, 1, 0, 0, 0, 0, 0);

    // Randomized instruction stream, including back-to-back multiplies.
    for (int n = 0; n < 200; n++) begin
      logic [2:0]  aluc;
      logic        wreg, m2reg, wmem, aluimm, shift, wz;
      logic [31:0] a, b, imm;
      aluc   = 3'($urandom_range(0, 7));
      wreg   = ($urandom_range(0, 3) != 0);
      m2reg  = 1'($urandom);
      wmem   = 1'($urandom);
      aluimm = 1'($urandom);
      shift  = (aluc inside {3'd4, 3'd5, 3'd6}) ? 1'($urandom) : 1'b0;
      wz     = 1'($urandom);
      a      = $urandom;
      b      = $urandom;
      imm    = $urandom;
      if (n % 5 == 0) b = a;
      if (n % 7 == 0) a = $urandom_range(0, 3);
      if (aluc == 3'd7 && !wreg) wz = 1'b0;
      run_instr(a, b, imm, 5'($urandom), aluc, wreg, m2reg, wmem, aluimm, shift, wz);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the five-stage pipeline, sitting between the ID/EXE pipeline register and the MEM stage. It performs single-cycle ALU and shift operations and a 32-cycle iterative multiply, and maintains the zero flag. It registers its results into the EXE/MEM boundary, so it also serves as the EXE/MEM pipeline register. During a multiply it raises a stall that freezes the upstream pipeline.

## Interface
Parameters: none; all widths are fixed at 32-bit data and 5-bit register number.

Ports, with clock and reset first:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- clrn  in  1  reset; asynchronous, active-low.
- exe_a, exe_b, exe_imm  in  32 each  operands and immediate from ID/EXE.
- exe_rn  in  5  destination register number.
- exe_aluc  in  3  operation select.
- exe_wreg, exe_m2reg, exe_wmem, exe_aluimm, exe_shift, exe_wz  in  1 each  control bits from ID/EXE.
- exe_stall  out  1  hold request to IF/ID and ID/EXE; combinational.
- mem_alu  out  32  registered ALU or multiply result.
- mem_b  out  32  registered store data, equal to exe_b.
- mem_rn  out  5  registered destination register.
- mem_wreg, mem_m2reg, mem_wmem  out  1 each  registered control bits.
- z  out  1  zero-flag register.

## Operation
- Operand A is {27'b0, exe_imm[10:6]} when exe_shift=1, otherwise exe_a.
- Operand B is exe_imm when exe_aluimm=1, otherwise exe_b.
- aluc encoding:
  - 000 ADD, 001 SUB, 010 AND, 011 OR: 32-bit results, wrap-around, no overflow trap.
  - 100 SLL, 101 SRL, 110 SRA: B shifted by A[4:0].
  - 111 MUL: low 32 bits of A*B. Because only the low word is kept, signed and unsigned operands give the same result.
- MUL start condition: state IDLE, exe_aluc=111 and exe_wreg=1. A bubble has exe_wreg=0, so a bubble carrying a stale aluc=111 never starts a multiply.
- FSM states:
  - IDLE: single-cycle ops pass straight through.
  - MUL: iterative radix-2 shift-add on latched operands (multiplicand, multiplier, rn, wz, m2reg) with a 5-bit counter.
- IDLE to MUL: on an edge where the start condition holds. At that edge: latch operands, clear the partial product, set count=0, and load a bubble into mem_* (mem_wreg=mem_wmem=0).
- MUL, count<31: one iteration per edge, count+1, and a bubble into mem_*.
- MUL, count=31: final iteration. The product goes to mem_alu with the latched rn/m2reg, mem_wreg=1, mem_wmem=0. z updates if the latched wz=1. State returns to IDLE.
- exe_stall=1 when (IDLE and start condition) or (MUL and count<31); otherwise 0. It is forced to 0 while clrn=0.
- While exe_stall=1, the ID/EXE inputs are held stable upstream and ignored here.
- In IDLE, each edge registers all mem_* from the current inputs (the pipeline-register path). z is loaded with (result==0) only when exe_wz=1.
- Bubble inputs (all write controls 0) propagate as bubbles; z is unchanged.

## Timing
- Reset, asynchronous on clrn low: state=IDLE, count=0; mem_alu, mem_b, mem_rn, mem_wreg, mem_m2reg, mem_wmem and z all 0; exe_stall=0.
- Reset asserted mid-MUL aborts the multiply. No result is written, and the first post-reset instruction is treated as new.
- Single-cycle op presented in cycle N: appears on mem_* after the edge ending cycle N (latency 1).
- MUL presented in cycle N:
  - exe_stall is high in cycles N..N+31 (32 cycles) and low in N+32.
  - mem_* carry bubbles after the edges ending N..N+31.
  - The product is on mem_* and z is updated after the edge ending N+32.
  - The next instruction is loaded by ID/EXE at that same edge and executes in cycle N+33.
- Back-to-back MULs: the second starts in cycle N+33. There are no extra idle cycles.
- z reflects the most recent wz=1 instruction that has completed. In the same cycle that a wz instruction completes, z still shows the old value (registered).

## Test plan
- Reset, then ADD with a=5, b=0xFFFFFFFB, wz=1, wreg=1, rn=3 -> next cycle mem_alu=0, z=1, mem_rn=3, mem_wreg=1.
- SUB with a=0x80000000, b=1, aluimm=0, wz=1 -> mem_alu=0x7FFFFFFF, z=0. Then SRA with shift=1, imm[10:6]=4, b=0x80000000 -> mem_alu=0xF8000000.
- Store with aluc=000, a=0x100, imm=8, aluimm=1, wmem=1, wreg=0, b=0xDEADBEEF -> mem_alu=0x108, mem_b=0xDEADBEEF, mem_wmem=1.
- MUL with a=7, b=0xFFFFFFFD, rn=9, wz=1 -> exe_stall high for exactly 32 cycles and 32 bubbles with mem_wreg=0. The 33rd edge gives mem_alu=0xFFFFFFEB, mem_rn=9, mem_wreg=1, z=0. The following ADD completes one cycle later.
- Bubble with aluc=111, wreg=0 -> exe_stall stays 0, the FSM stays IDLE, and mem_wreg=0.
- MUL started, clrn pulsed low at count=10 -> all outputs and exe_stall are 0 immediately. After release, an ADD with a=1, b=2 gives mem_alu=3 one cycle later, and no stale product ever appears.
